// File: rtl/rotpar_chk.sv
// Word-permuting datapath stage with header/sequence checking.
// One-deep output register, valid/ready handshake, saturating error count.
module rotpar_chk #(
    parameter int BUS_SIZE  = 60,
    parameter int WORD_SIZE = 6,
    localparam int WORD_NUM = BUS_SIZE / WORD_SIZE,
    localparam int ROT_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUS_SIZE-1:0] data_in,
    input  logic [1:0]          mode,
    input  logic [ROT_W-1:0]    rot_amt,
    input  logic                err_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUS_SIZE-1:0] data_out,
    output logic [WORD_NUM-1:0] control_out,
    output logic                error_out,
    output logic [1:0]          err_code,
    output logic [15:0]         err_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIRST_PKT = 3'd1,
        REG_PKT   = 3'd2,
        F_ERR     = 3'd3,
        SEQ_ERR   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_FRM  = 2'b01;
    localparam logic [1:0] ERR_SEQ  = 2'b10;

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   exp_q, exp_d, exp_inc;
    logic [WORD_SIZE-1:0]   seq;
    logic                   hdr_ok, seq_zero, accept;
    logic [1:0]             code_d;
    logic                   err_d;
    logic [BUS_SIZE-1:0]    perm;
    logic [WORD_NUM-1:0]    ctrl;
    int                     rot_i;
    int                     src;

    assign in_ready = reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign hdr_ok   = &data_in[BUS_SIZE-1 -: WORD_SIZE];
    assign seq      = data_in[WORD_SIZE-1:0];
    assign seq_zero = (seq == '0);
    assign exp_inc  = (exp_q == '1) ? WORD_SIZE'(1) : exp_q + 1'b1;
    assign err_d    = (code_d != ERR_NONE);

    // Word permutation selected by mode; out-of-range rotation acts as zero.
    always_comb begin
        perm  = '0;
        src   = 0;
        rot_i = (int'(rot_amt) >= WORD_NUM) ? 0 : int'(rot_amt);
        for (int k = 0; k < WORD_NUM; k++) begin
            unique case (mode)
                2'b00: src = k;
                2'b01: src = WORD_NUM - 1 - k;
                2'b10: src = (k + WORD_NUM - rot_i) % WORD_NUM;
                2'b11: src = (k + rot_i) % WORD_NUM;
            endcase
            perm[k*WORD_SIZE +: WORD_SIZE] =
                data_in[src*WORD_SIZE +: WORD_SIZE];
        end
    end

    // Per-word nonzero flags taken from the unpermuted input.
    always_comb begin
        ctrl = '0;
        for (int i = 0; i < WORD_NUM; i++)
            ctrl[i] = |data_in[i*WORD_SIZE +: WORD_SIZE];
    end

    // Packet tracker: next state, expected sequence and error code.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        code_d  = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (accept && hdr_ok) begin
                    if (seq_zero) begin
                        state_d = FIRST_PKT;
                        exp_d   = WORD_SIZE'(1);
                    end else begin
                        state_d = F_ERR;
                        code_d  = ERR_FRM;
                    end
                end
            end
            FIRST_PKT, REG_PKT: begin
                if (accept) begin
                    if (!hdr_ok) begin
                        state_d = F_ERR;
                        code_d  = ERR_FRM;
                    end else if (seq_zero) begin
                        state_d = FIRST_PKT;
                        exp_d   = WORD_SIZE'(1);
                    end else if (seq == exp_q) begin
                        state_d = REG_PKT;
                        exp_d   = exp_inc;
                    end else begin
                        state_d = SEQ_ERR;
                        code_d  = ERR_SEQ;
                    end
                end
            end
            F_ERR, SEQ_ERR: begin
                if (accept) begin
                    if (hdr_ok && seq_zero) begin
                        state_d = FIRST_PKT;
                        exp_d   = WORD_SIZE'(1);
                    end else begin
                        state_d = F_ERR;
                        code_d  = ERR_FRM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tracker state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
        end
    end

    // Output register: load on accept, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            data_out    <= '0;
            control_out <= '0;
            error_out   <= 1'b0;
            err_code    <= ERR_NONE;
        end else if (accept) begin
            out_valid   <= 1'b1;
            data_out    <= perm;
            control_out <= ctrl;
            error_out   <= err_d;
            err_code    <= code_d;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Saturating count of errored beats; clear wins but keeps a same-cycle error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= (accept && err_d) ? 16'd1 : 16'd0;
        end else if (accept && err_d && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rotpar_chk.sv
// Bench for rotpar_chk: vector table, directed corner sequences,
// and random traffic against a word-level reference model.
module tb_rotpar_chk;

    localparam int BS = 60;
    localparam int WS = 6;
    localparam int WN = 10;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, err_clr;
    logic          out_valid, out_ready, error_out;
    logic [BS-1:0] data_in, data_out;
    logic [1:0]    mode, err_code;
    logic [RW-1:0] rot_amt;
    logic [WN-1:0] control_out;
    logic [15:0]   err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rotpar_chk #(.BUS_SIZE(BS), .WORD_SIZE(WS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .mode(mode), .rot_amt(rot_amt),
        .err_clr(err_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .control_out(control_out),
        .error_out(error_out), .err_code(err_code),
        .err_cnt(err_cnt)
    );

    typedef int wa_t [WN];

    typedef struct {
        logic [1:0] md;
        int         rot;
        wa_t        win;
        wa_t        wout;
        logic [9:0] ctrl;
        logic       err;
        logic [1:0] code;
        int         cnt;
    } vec_t;

    // reference model: word view, packet phase 0=idle 1=in packet 2=errored
    bit          m_ov;
    logic [BS-1:0] m_do;
    logic [WN-1:0] m_co;
    bit          m_eo;
    logic [1:0]  m_ec;
    int          m_cnt, m_ph, m_exp;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [BS-1:0] packw(input wa_t w);
        logic [BS-1:0] r = '0;
        for (int k = 0; k < WN; k++) r[k*WS +: WS] = WS'(w[k]);
        return r;
    endfunction

    function automatic logic [BS-1:0] mkd(input int hdr, input int sq);
        wa_t w = '{default: 0};
        w[WN-1] = hdr;
        w[0]    = sq;
        return packw(w);
    endfunction

    function automatic vec_t mkv(input logic [1:0] md, input int rot,
                                 input wa_t wi, input wa_t wo,
                                 input logic [9:0] c, input logic e,
                                 input logic [1:0] cd, input int n);
        vec_t v;
        v.md = md; v.rot = rot; v.win = wi; v.wout = wo;
        v.ctrl = c; v.err = e; v.code = cd; v.cnt = n;
        return v;
    endfunction

    task automatic model_step();
        int  wi[WN];
        int  wo[WN];
        int  r, sq, code;
        bit  acc, hdr;
        if (!reset) begin
            m_ov = 0; m_do = '0; m_co = '0; m_eo = 0; m_ec = 0;
            m_cnt = 0; m_ph = 0; m_exp = 0;
            return;
        end
        acc = in_valid && (!m_ov || out_ready);
        if (!acc) begin
            if (out_ready) m_ov = 0;
            if (err_clr) m_cnt = 0;
            return;
        end
        for (int k = 0; k < WN; k++) wi[k] = int'(data_in[k*WS +: WS]);
        r = (int'(rot_amt) >= WN) ? 0 : int'(rot_amt);
        for (int k = 0; k < WN; k++) begin
            case (mode)
                2'd0: wo[k] = wi[k];
                2'd1: wo[k] = wi[WN-1-k];
                2'd2: wo[(k + r) % WN] = wi[k];
                default: wo[k] = wi[(k + r) % WN];
            endcase
        end
        hdr  = (wi[WN-1] == 63);
        sq   = wi[0];
        code = 0;
        if (hdr && sq == 0) begin
            m_ph = 1; m_exp = 1;
        end else if (m_ph == 0) begin
            if (hdr) begin m_ph = 2; code = 1; end
        end else if (m_ph == 1) begin
            if (!hdr) begin m_ph = 2; code = 1; end
            else if (sq == m_exp) m_exp = (m_exp == 63) ? 1 : m_exp + 1;
            else begin m_ph = 2; code = 2; end
        end else begin
            code = 1;
        end
        for (int k = 0; k < WN; k++) begin
            m_do[k*WS +: WS] = WS'(wo[k]);
            m_co[k] = (wi[k] != 0);
        end
        m_ov = 1;
        m_eo = (code != 0);
        m_ec = 2'(code);
        if (err_clr) m_cnt = m_eo ? 1 : 0;
        else if (m_eo && m_cnt < 65535) m_cnt++;
    endtask

    task automatic cyc();
        #1;
        chk("in_ready", 64'(in_ready), 64'(reset && (!m_ov || out_ready)));
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("data_out", 64'(data_out), 64'(m_do));
        chk("control_out", 64'(control_out), 64'(m_co));
        chk("error_out", 64'(error_out), 64'(m_eo));
        chk("err_code", 64'(err_code), 64'(m_ec));
        chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
    endtask

    task automatic do_reset();
        reset = 0; in_valid = 0; err_clr = 0; out_ready = 1;
        cyc();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_ctrl", 64'(control_out), 64'd0);
        chk("rst_err", 64'({error_out, err_code}), 64'd0);
        chk("rst_cnt", 64'(err_cnt), 64'd0);
        reset = 1;
    endtask

    task automatic beat(input logic [BS-1:0] d, input logic [1:0] md = 2'd0,
                        input int rot = 0);
        in_valid = 1; data_in = d; mode = md; rot_amt = RW'(rot);
        cyc();
    endtask

    vec_t tbl[8];
    logic [BS-1:0] held;

    initial begin
        reset = 0; in_valid = 0; out_ready = 1; err_clr = 0;
        data_in = '0; mode = 0; rot_amt = 0;
        m_ov = 0; m_do = '0; m_co = '0; m_eo = 0; m_ec = 0;
        m_cnt = 0; m_ph = 0; m_exp = 0;

        tbl[0] = mkv(2'd1, 0, '{0,0,0,0,0,0,0,0,0,63},
                     '{63,0,0,0,0,0,0,0,0,0}, 10'h200, 0, 2'd0, 0);
        tbl[1] = mkv(2'd0, 0, '{1,0,0,0,0,0,0,0,0,63},
                     '{1,0,0,0,0,0,0,0,0,63}, 10'h201, 0, 2'd0, 0);
        tbl[2] = mkv(2'd3, 2, '{2,5,0,0,0,0,0,0,7,63},
                     '{0,0,0,0,0,0,7,63,2,5}, 10'h303, 0, 2'd0, 0);
        tbl[3] = mkv(2'd2, 3, '{0,1,2,3,4,5,6,7,8,9},
                     '{7,8,9,0,1,2,3,4,5,6}, 10'h3FE, 1, 2'd1, 1);
        tbl[4] = mkv(2'd2, 12, '{0,1,2,3,4,5,6,7,8,9},
                     '{0,1,2,3,4,5,6,7,8,9}, 10'h3FE, 1, 2'd1, 2);
        tbl[5] = mkv(2'd0, 0, '{0,0,0,0,0,0,0,0,0,63},
                     '{0,0,0,0,0,0,0,0,0,63}, 10'h200, 0, 2'd0, 2);
        tbl[6] = mkv(2'd0, 0, '{5,0,0,0,0,0,0,0,0,63},
                     '{5,0,0,0,0,0,0,0,0,63}, 10'h201, 1, 2'd2, 3);
        tbl[7] = mkv(2'd1, 0, '{3,0,0,0,0,0,0,0,0,63},
                     '{63,0,0,0,0,0,0,0,0,3}, 10'h201, 1, 2'd1, 4);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            beat(packw(tbl[i].win), tbl[i].md, tbl[i].rot);
            chk($sformatf("vec%0d_data", i), 64'(data_out),
                64'(packw(tbl[i].wout)));
            chk($sformatf("vec%0d_ctrl", i), 64'(control_out),
                64'(tbl[i].ctrl));
            chk($sformatf("vec%0d_err", i), 64'({error_out, err_code}),
                64'({tbl[i].err, tbl[i].code}));
            chk($sformatf("vec%0d_cnt", i), 64'(err_cnt), 64'(tbl[i].cnt));
        end

        // clean sequence then a gap
        do_reset();
        beat(mkd(63, 0));
        beat(mkd(63, 1));
        beat(mkd(63, 2));
        chk("seq2_clean", 64'({error_out, err_code}), 64'd0);
        beat(mkd(63, 5));
        chk("seq_gap_err", 64'({error_out, err_code}), 64'({1'b1, 2'b10}));
        chk("seq_gap_cnt", 64'(err_cnt), 64'd1);

        // framing error inside a packet, then recovery
        beat(mkd(63, 0));
        beat(mkd(63, 1));
        beat(mkd(0, 2));
        chk("frm_err", 64'({error_out, err_code}), 64'({1'b1, 2'b01}));
        beat(mkd(63, 0));
        chk("frm_recover", 64'({error_out, err_code}), 64'd0);
        beat(mkd(63, 1));
        chk("frm_recover_seq1", 64'(error_out), 64'd0);

        // backpressure holds the output and stalls the input
        beat(mkd(63, 0));
        held = data_out;
        out_ready = 0;
        data_in = mkd(63, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold", 64'(data_out), 64'(held));
        end
        out_ready = 1;
        cyc();
        chk("bp_release_data", 64'(data_out), 64'(mkd(63, 1)));
        chk("bp_release_err", 64'(error_out), 64'd0);

        // expected counter wraps 63 -> 1
        beat(mkd(63, 0));
        for (int s = 1; s < 64; s++) beat(mkd(63, s));
        chk("seq63_clean", 64'(error_out), 64'd0);
        beat(mkd(63, 1));
        chk("wrap_clean", 64'({error_out, err_code}), 64'd0);

        // reset mid-stream, then clear racing an error
        do_reset();
        for (int i = 0; i < 5; i++) beat(mkd(63, 3));
        chk("cnt5", 64'(err_cnt), 64'd5);
        reset = 0;
        beat(mkd(63, 0));
        chk("midrst_ready", 64'(in_ready), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data", 64'(data_out), 64'd0);
        chk("midrst_cnt", 64'(err_cnt), 64'd0);
        reset = 1;
        err_clr = 1;
        beat(mkd(63, 7));
        chk("clr_with_err", 64'(err_cnt), 64'd1);
        in_valid = 0;
        cyc();
        chk("clr_alone", 64'(err_cnt), 64'd0);
        err_clr = 0;

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            wa_t w;
            int  pick;
            reset     = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 29) == 0);
            mode      = 2'($urandom);
            rot_amt   = RW'($urandom);
            for (int k = 1; k < WN - 1; k++)
                w[k] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 63);
            w[WN-1] = ($urandom_range(0, 9) < 8) ? 63 : $urandom_range(0, 63);
            pick = $urandom_range(0, 5);
            if (pick == 0) w[0] = 0;
            else if (pick < 5) w[0] = m_exp;
            else w[0] = $urandom_range(0, 63);
            data_in = packw(w);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
